// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment scan driver.
//   - Segment codes in active-high {g,f,e,d,c,b,a} order (SEG_0..SEG_9, SEG_DASH, SEG_OFF)
//   - bcd_to_seg: BCD digit to segment code; codes 10..15 show a dash
//   - phase_t: slot phase, BLANK (ghosting dead-time) or SHOW
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } phase_t;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD to 7-segment decoder, active-high output.
// Ports:
//   bcd  in  4  BCD digit (10..15 decode to a dash)
//   seg  out 7  {g,f,e,d,c,b,a}, 1 = segment lit
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = bcd_to_seg(bcd);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexes DIGITS BCD digits onto one common-segment 7-seg display.
// Each digit gets a slot of TICK_DIV = CLK_HZ/SCAN_HZ cycles; the first BLANK_CYCLES of a
// slot drive everything off to suppress ghosting. The bcd/dp inputs are snapshotted once
// per frame (as the scan wraps from the last digit back to digit 0) so a multi-digit value
// is never shown torn. Outputs are registered (1-cycle latency).
// Optional build macro: LEADING_ZERO_BLANK_EN -- blank zero digits above the most
// significant nonzero digit (digit 0 always shown; a blanked digit still shows its dp).
// Ports:
//   clk     in  1         clock
//   reset   in  1         synchronous reset, active-high
//   enable  in  1         0 blanks the display; scanning continues
//   bcd     in  4*DIGITS  digit i = bcd[4i+3:4i], digit 0 rightmost on an[0]
//   dp      in  DIGITS    decimal point per digit, 1 = lit
//   seg     out 7         {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW
//   dp_out  out 1         decimal point of the active digit, polarity per ACTIVE_LOW
//   an      out DIGITS    one-hot digit enable, polarity per ACTIVE_LOW
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned SCAN_HZ      = 1000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic [DIGITS-1:0]     dp,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an
);

  localparam int unsigned TICK_DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    slot_cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] frame;
  logic [DIGITS-1:0]   dp_frame;

  logic                slot_end;
  logic                frame_end;
  phase_t              phase;
  logic [3:0]          cur_digit;
  logic [6:0]          dec_seg;
  logic                cur_dp;
  logic                blank_digit;

  logic [DIGITS-1:0]   an_nxt;
  logic [6:0]          seg_nxt;
  logic                dp_nxt;

  assign slot_end  = (slot_cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign phase     = (slot_cnt < CNT_BLANK) ? BLANK : SHOW;
  assign cur_digit = frame[{idx, 2'b00} +: 4];
  assign cur_dp    = dp_frame[idx];

  // Scan position and frame snapshot
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt <= '0;
      idx      <= '0;
      frame    <= '0;
      dp_frame <= '0;
    end else begin
      if (slot_end) begin
        slot_cnt <= '0;
        idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
      if (frame_end) begin
        frame    <= bcd;
        dp_frame <= dp;
      end
    end
  end

  seg7_decode u_decode (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lz_mask;

  // Walk from the top digit down; a digit is blanked while no nonzero digit has been
  // seen at or above it. Digit 0 is never part of the mask.
  always_comb begin
    logic seen_nz;
    lz_mask = '0;
    seen_nz = 1'b0;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      if (frame[4*i +: 4] != 4'd0) seen_nz = 1'b1;
      lz_mask[i] = !seen_nz;
    end
  end

  assign blank_digit = lz_mask[idx];
`else
  assign blank_digit = 1'b0;
`endif

  // Next pin values in active-high terms; priority enable > phase
  always_comb begin
    an_nxt  = '0;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b0;
    if (enable && (phase == SHOW)) begin
      if (!blank_digit) begin
        an_nxt[idx] = 1'b1;
        seg_nxt     = dec_seg;
        dp_nxt      = cur_dp;
      end else if (cur_dp) begin
        an_nxt[idx] = 1'b1;
        dp_nxt      = 1'b1;
      end
    end
  end

  // Output registers; polarity applied by XOR with ACTIVE_LOW
  always_ff @(posedge clk) begin
    if (reset) begin
      an     <= {DIGITS{ACTIVE_LOW}};
      seg    <= {7{ACTIVE_LOW}};
      dp_out <= ACTIVE_LOW;
    end else begin
      an     <= an_nxt ^ {DIGITS{ACTIVE_LOW}};
      seg    <= seg_nxt ^ {7{ACTIVE_LOW}};
      dp_out <= dp_nxt ^ ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed bench for seg7_scan_driver with DIGITS=4, TICK_DIV=10,
// BLANK_CYCLES=2, ACTIVE_LOW=1. 'pos' counts posedges since reset release minus one, so
// the pins sampled at the following negedge reflect scan position pos
// (slot = (pos/10)%4, cycle in slot = pos%10). Snapshots happen at pos%40 == 39.
module tb_seg7_scan_driver;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] bcd;
  logic [3:0]  dp;
  logic [6:0]  seg;
  logic        dp_out;
  logic [3:0]  an;

  int unsigned n_cmp;
  int unsigned n_err;
  int          pos;

  seg7_scan_driver #(
    .DIGITS       (4),
    .CLK_HZ       (1000),
    .SCAN_HZ      (100),
    .BLANK_CYCLES (2),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bcd    (bcd),
    .dp     (dp),
    .seg    (seg),
    .dp_out (dp_out),
    .an     (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_pins(input string tag, input logic [3:0] an_e,
                            input logic [6:0] seg_e, input logic dp_e);
    check({tag, ".an"}, 32'(an), 32'(an_e));
    check({tag, ".seg"}, 32'(seg), 32'(seg_e));
    check({tag, ".dp"}, 32'(dp_out), 32'(dp_e));
  endtask

  // Advance until the pins show scan position p, then sample at the negedge
  task automatic run_to(input int p);
    while (pos < p) begin
      @(posedge clk);
      pos++;
    end
    @(negedge clk);
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    pos    = -1;
    reset  = 1'b1;
    enable = 1'b1;
    bcd    = 16'h1234;
    dp     = 4'b0000;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_pins("reset", 4'b1111, 7'h7F, 1'b1);
    reset = 1'b0;

    // Frame 0 shows the reset frame (all zeros)
    run_to(0);  check_pins("f0_p0_blank", 4'b1111, 7'h7F, 1'b1);
    run_to(2);  check_pins("f0_p2_zero",  4'b1110, 7'h40, 1'b1);

    // Frame 1: 1234
    run_to(40); check_pins("f1_s0_dead0", 4'b1111, 7'h7F, 1'b1);
    run_to(41); check_pins("f1_s0_dead1", 4'b1111, 7'h7F, 1'b1);
    run_to(42); check_pins("f1_s0_show",  4'b1110, 7'h19, 1'b1);
    run_to(49); check_pins("f1_s0_last",  4'b1110, 7'h19, 1'b1);
    run_to(50); check_pins("f1_s1_dead",  4'b1111, 7'h7F, 1'b1);
    run_to(52); check_pins("f1_s1_show",  4'b1101, 7'h30, 1'b1);
    run_to(62); check_pins("f1_s2_show",  4'b1011, 7'h24, 1'b1);
    run_to(72); check_pins("f1_s3_show",  4'b0111, 7'h79, 1'b1);

    // Frame 2: input changes mid-frame, must stay invisible until the wrap
    run_to(90); bcd = 16'h5678;
    run_to(92);  check_pins("snap_s1_old", 4'b1101, 7'h30, 1'b1);
    run_to(102); check_pins("snap_s2_old", 4'b1011, 7'h24, 1'b1);
    run_to(112); check_pins("snap_s3_old", 4'b0111, 7'h79, 1'b1);

    // Frame 3: 5678
    run_to(122); check_pins("snap_s0_new", 4'b1110, 7'h00, 1'b1);
    run_to(130); bcd = 16'h00A0; dp = 4'b0010;
    run_to(152); check_pins("snap_s3_new", 4'b0111, 7'h12, 1'b1);

    // Frame 4: 00A0 with dp on digit 1
    run_to(162); check_pins("dash_s0", 4'b1110, 7'h40, 1'b1);
    run_to(172); check_pins("dash_s1", 4'b1101, 7'h3F, 1'b0);
    run_to(175); enable = 1'b0;
    run_to(176); check_pins("disable", 4'b1111, 7'h7F, 1'b1);
    enable = 1'b1;
    run_to(177); check_pins("reenable", 4'b1101, 7'h3F, 1'b0);
    run_to(180); bcd = 16'h0070; dp = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    run_to(182); check_pins("dash_s2", 4'b1111, 7'h7F, 1'b1);
    run_to(192); check_pins("dash_s3", 4'b1111, 7'h7F, 1'b1);
`else
    run_to(182); check_pins("dash_s2", 4'b1011, 7'h40, 1'b1);
    run_to(192); check_pins("dash_s3", 4'b0111, 7'h40, 1'b1);
`endif

    // Frame 5: 0070, leading-zero handling
    run_to(202); check_pins("lz_s0", 4'b1110, 7'h40, 1'b1);
    run_to(212); check_pins("lz_s1", 4'b1101, 7'h78, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
    run_to(222); check_pins("lz_s2", 4'b1111, 7'h7F, 1'b1);
    run_to(232); check_pins("lz_s3", 4'b1111, 7'h7F, 1'b1);
`else
    run_to(222); check_pins("lz_s2", 4'b1011, 7'h40, 1'b1);
    run_to(232); check_pins("lz_s3", 4'b0111, 7'h40, 1'b1);
`endif

    // Reset mid-slot: pins off at once, scan restarts at slot 0 with a zero frame
    run_to(245);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_pins("midreset", 4'b1111, 7'h7F, 1'b1);
    reset = 1'b0;
    pos   = -1;
    run_to(1); check_pins("restart_dead", 4'b1111, 7'h7F, 1'b1);
    run_to(2); check_pins("restart_s0",   4'b1110, 7'h40, 1'b1);
    run_to(12); check_pins("restart_s1",  4'b1101, 7'h40, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
